// File: rtl/mips_mem_mapper.sv
// mips_mem_mapper
//   Memory subsystem behind the multicycle MIPS core's single memory port.
//   Decodes the byte address into a word-addressed unified RAM and a small
//   memory-mapped I/O page (LEDs, synchronized switches, free-running cycle
//   counter, TX byte FIFO and its drop counter).
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   mem_wr_ena   write strobe from the core, sampled at posedge clk
//   mem_addr     byte address from the core (bits [1:0] ignored)
//   mem_wr_data  write data from the core
//   mem_rd_data  read data to the core, combinational from mem_addr
//   switches     asynchronous board switches
//   leds         LED register
//   tx_data      TX FIFO head byte
//   tx_valid     TX FIFO non-empty
//   tx_ready     consumer accepts tx_data this cycle
//
// I/O page (byte addresses)
//   0xFFFF_0000  LED   R/W, low 16 bits
//   0xFFFF_0004  SW    RO, synchronized switches
//   0xFFFF_0008  CYC   R, write clears
//   0xFFFF_000C  TX    W pushes byte, R returns {full, empty}
//   0xFFFF_0010  DROP  RO, saturating count of rejected pushes

module mips_mem_mapper #(
    parameter int N          = 32,
    parameter int D_LENGTH   = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_wr_ena,
    input  logic [N-1:0] mem_addr,
    input  logic [N-1:0] mem_wr_data,
    output logic [N-1:0] mem_rd_data,
    input  logic [15:0]  switches,
    output logic [15:0]  leds,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready
);

    localparam int AW = (D_LENGTH > 1) ? $clog2(D_LENGTH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Word-index constants (byte address >> 2)
    localparam logic [N-3:0] RAM_WORDS = (N-2)'(D_LENGTH);
    localparam logic [N-3:0] IO_LED    = (N-2)'(32'hFFFF_0000 >> 2);
    localparam logic [N-3:0] IO_SW     = (N-2)'(32'hFFFF_0004 >> 2);
    localparam logic [N-3:0] IO_CYC    = (N-2)'(32'hFFFF_0008 >> 2);
    localparam logic [N-3:0] IO_TX     = (N-2)'(32'hFFFF_000C >> 2);
    localparam logic [N-3:0] IO_DROP   = (N-2)'(32'hFFFF_0010 >> 2);

    logic [N-3:0] word_idx;
    logic         ram_hit;
    logic         unused_addr_bits;

    assign word_idx         = mem_addr[N-1:2];
    assign ram_hit          = (word_idx < RAM_WORDS);
    assign unused_addr_bits = ^mem_addr[1:0];

    // ------------------------------------------------------------------
    // Unified RAM: asynchronous read, synchronous write, never reset
    // ------------------------------------------------------------------
    logic [N-1:0] ram [0:D_LENGTH-1];

    always_ff @(posedge clk) begin
        if (mem_wr_ena && ram_hit) begin
            ram[word_idx[AW-1:0]] <= mem_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // I/O registers
    // ------------------------------------------------------------------
    logic [15:0]   leds_q, leds_d;
    logic [15:0]   sw_meta_q, sw_sync_q;
    logic [N-1:0]  cyc_q, cyc_d;
    logic [N-1:0]  drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];

    logic wr_led, wr_cyc, wr_tx;
    logic fifo_full, fifo_empty;
    logic push, pop, drop_req;

    assign wr_led = mem_wr_ena && !ram_hit && (word_idx == IO_LED);
    assign wr_cyc = mem_wr_ena && !ram_hit && (word_idx == IO_CYC);
    assign wr_tx  = mem_wr_ena && !ram_hit && (word_idx == IO_TX);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the consumer is draining.
    assign pop      = !fifo_empty && tx_ready;
    assign push     = wr_tx && (!fifo_full || pop);
    assign drop_req = wr_tx && !push;

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_mem[rd_ptr_q];
    assign leds     = leds_q;

    always_comb begin
        leds_d   = wr_led ? mem_wr_data[15:0] : leds_q;
        cyc_d    = wr_cyc ? '0 : cyc_q + 1'b1;
        drop_d   = (drop_req && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cyc_q     <= '0;
            drop_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            leds_q    <= leds_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            cyc_q     <= cyc_d;
            drop_q    <= drop_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_wr_data[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd_data = '0;
        if (ram_hit) begin
            mem_rd_data = ram[word_idx[AW-1:0]];
        end else begin
            case (word_idx)
                IO_LED:  mem_rd_data = N'(leds_q);
                IO_SW:   mem_rd_data = N'(sw_sync_q);
                IO_CYC:  mem_rd_data = cyc_q;
                IO_TX:   mem_rd_data = N'({fifo_full, fifo_empty});
                IO_DROP: mem_rd_data = drop_q;
                default: mem_rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_mapper.sv
`timescale 1ns/1ps
module tb_mips_mem_mapper;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_SW   = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
    localparam logic [31:0] A_TX   = 32'hFFFF_000C;
    localparam logic [31:0] A_DROP = 32'hFFFF_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr_ena;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic [15:0] switches;
    logic [15:0] leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;
    int drop_model = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  tx_sb [$];

    always #5 clk = ~clk;

    mips_mem_mapper #(.N(32), .D_LENGTH(1024), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wr_ena  (mem_wr_ena),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .switches    (switches),
        .leds        (leds),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic sig_chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        exp_q.push_back(expv);
        check(tag, obs);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] expv);
        exp_q.push_back(expv);
        mem_addr = addr;
        #1;
        check(tag, mem_rd_data);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_addr    = addr;
        mem_wr_data = data;
        mem_wr_ena  = 1'b1;
        @(negedge clk);
        mem_wr_ena  = 1'b0;
    endtask

    // Push while tx_ready is low: the model accepts up to 4 bytes.
    task automatic tx_push(input logic [7:0] b);
        if (tx_sb.size() < 4) tx_sb.push_back(b);
        else drop_model++;
        wr(A_TX, {24'h0, b});
    endtask

    task automatic drain(input string tag);
        int budget = 20;
        while (tx_sb.size() != 0 && budget > 0) begin
            #1;
            if (tx_valid && tx_ready) begin
                exp_q.push_back(32'(tx_sb.pop_front()));
                check(tag, 32'(tx_data));
            end
            @(negedge clk);
            budget--;
        end
        checks++;
        assert (tx_sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout observed=%0d bytes pending expected=0", tag, tx_sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        mem_wr_ena  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        switches    = '0;
        tx_ready    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        sig_chk("rst_leds", 32'(leds), 32'h0);
        sig_chk("rst_txv", 32'(tx_valid), 32'h0);
        rd_chk("rst_cyc", A_CYC, 32'h0);
        rd_chk("rst_drop", A_DROP, 32'h0);
        rd_chk("rst_stat", A_TX, 32'h1);
        repeat (5) @(negedge clk);
        rd_chk("cyc5", A_CYC, 32'd5);

        // RAM, including the out-of-range alias case and the last word
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_1000, 32'h2222_2222);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0FFC, 32'hCAFE_F00D);
        rd_chk("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        rd_chk("ram_oor", 32'h0000_1000, 32'h0);
        @(negedge clk);
        rd_chk("ram_w0", 32'h0000_0000, 32'h1111_1111);
        rd_chk("ram_last", 32'h0000_0FFC, 32'hCAFE_F00D);
        rd_chk("unmapped_io", 32'hFFFF_0014, 32'h0);

        // LED and read-only SW
        wr(A_LED, 32'h1234_ABCD);
        sig_chk("leds", 32'(leds), 32'h0000_ABCD);
        rd_chk("led_rd", A_LED, 32'h0000_ABCD);
        wr(A_SW, 32'hFFFF_FFFF);
        wr(32'hFFFF_0020, 32'h0000_FFFF);
        rd_chk("sw_ro", A_SW, 32'h0);
        sig_chk("unmapped_wr", 32'(leds), 32'h0000_ABCD);

        // Switch synchronizer latency
        @(negedge clk);
        switches = 16'h00F0;
        rd_chk("sw_lat0", A_SW, 32'h0);
        @(negedge clk);
        rd_chk("sw_lat1", A_SW, 32'h0);
        @(negedge clk);
        rd_chk("sw_lat2", A_SW, 32'h0000_00F0);

        // Cycle counter clear
        wr(A_CYC, 32'h0000_1234);
        rd_chk("cyc_clr0", A_CYC, 32'd0);
        @(negedge clk);
        rd_chk("cyc_clr1", A_CYC, 32'd1);
        @(negedge clk);
        rd_chk("cyc_clr2", A_CYC, 32'd2);

        // FIFO fill past full, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) tx_push(8'(8'h41 + i));
        rd_chk("full_stat", A_TX, 32'h2);
        rd_chk("drop1", A_DROP, 32'(drop_model));
        sig_chk("head", 32'(tx_data), 32'(tx_sb[0]));
        @(negedge clk);
        sig_chk("head_stable", 32'(tx_data), 32'(tx_sb[0]));
        tx_ready = 1'b1;
        drain("drain1");
        #1;
        sig_chk("drain1_txv", 32'(tx_valid), 32'h0);
        rd_chk("empty_stat", A_TX, 32'h1);

        // Pop while empty is harmless; push into empty has no bypass
        @(negedge clk);
        rd_chk("empty_pop", A_TX, 32'h1);
        @(negedge clk);
        mem_addr    = A_TX;
        mem_wr_data = 32'h0000_0077;
        mem_wr_ena  = 1'b1;
        #1;
        sig_chk("no_bypass", 32'(tx_valid), 32'h0);
        @(negedge clk);
        mem_wr_ena = 1'b0;
        #1;
        sig_chk("push_txv", 32'(tx_valid), 32'h1);
        sig_chk("push_data", 32'(tx_data), 32'h77);
        @(negedge clk);
        #1;
        sig_chk("push_popped", 32'(tx_valid), 32'h0);

        // Full FIFO with simultaneous push and pop
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) tx_push(8'(8'h51 + i));
        rd_chk("full2_stat", A_TX, 32'h2);
        @(negedge clk);
        tx_ready    = 1'b1;
        mem_addr    = A_TX;
        mem_wr_data = 32'h0000_0055;
        mem_wr_ena  = 1'b1;
        tx_sb.push_back(8'h55);
        #1;
        exp_q.push_back(32'(tx_sb.pop_front()));
        check("sim_head", 32'(tx_data));
        @(negedge clk);
        mem_wr_ena = 1'b0;
        rd_chk("sim_drop", A_DROP, 32'(drop_model));
        drain("drain2");
        #1;
        sig_chk("drain2_txv", 32'(tx_valid), 32'h0);

        // Reset mid-stream
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) tx_push(8'(8'h61 + i));
        wr(A_LED, 32'h0000_5A5A);
        sig_chk("pre_rst_txv", 32'(tx_valid), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_sb.delete();
        drop_model = 0;
        sig_chk("rst2_txv", 32'(tx_valid), 32'h0);
        sig_chk("rst2_leds", 32'(leds), 32'h0);
        rd_chk("rst2_cyc", A_CYC, 32'h0);
        rd_chk("rst2_drop", A_DROP, 32'(drop_model));
        rd_chk("rst2_stat", A_TX, 32'h1);
        rd_chk("rst2_sw", A_SW, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
